// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU mixer types and pixel constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MIX,
    DRAIN,
    DONE
  } ppu_state_e;

  localparam int TRANSPARENT_COL = 0;
  localparam int BACKDROP        = 0;

endpackage

// File: rtl/layer_prio_resolve.sv
// rtl/layer_prio_resolve.sv - combinational N-way pick of the visible layer pixel.
module layer_prio_resolve
  import ppu_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int PAL_W      = 5,
  parameter int COL_W      = 4,
  parameter int PRIO_W     = 2,
  parameter int PIX_W      = PAL_W + COL_W
) (
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS*PIX_W-1:0]  layer_pixel,
  input  logic [NUM_LAYERS*PRIO_W-1:0] layer_prio,
  output logic [PIX_W-1:0]             win_pixel
);

  logic              found;
  logic [PRIO_W-1:0] best_prio;

  // Strict greater-than keeps the earlier (lower-index) layer on a priority tie.
  always_comb begin
    win_pixel = PIX_W'(BACKDROP);
    found     = 1'b0;
    best_prio = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_en[i] &&
          (layer_pixel[i*PIX_W +: COL_W] != COL_W'(TRANSPARENT_COL)) &&
          (!found || (layer_prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
        found     = 1'b1;
        best_prio = layer_prio[i*PRIO_W +: PRIO_W];
        win_pixel = layer_pixel[i*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/layer_mixer.sv
// rtl/layer_mixer.sv - N-layer row mixer: waits for engines, sweeps the row, writes resolved pixels.
module layer_mixer
  import ppu_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int ROW_WIDTH  = 320,
  parameter int PAL_W      = 5,
  parameter int COL_W      = 4,
  parameter int PRIO_W     = 2,
  parameter int RD_LAT     = 1,
  parameter int ADDR_W     = $clog2(ROW_WIDTH),
  parameter int PIX_W      = PAL_W + COL_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prep,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS-1:0]        layer_done,
  output logic [ADDR_W-1:0]            pixel_addr,
  input  logic [NUM_LAYERS*PIX_W-1:0]  layer_pixel,
  input  logic [NUM_LAYERS*PRIO_W-1:0] layer_prio,
  output logic [PIX_W-1:0]             rowram_wrdata,
  output logic [ADDR_W-1:0]            rowram_wraddr,
  output logic                         rowram_wren,
  output logic                         mix_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WIDTH - 1);
  localparam int                DCNT_W    = $clog2(RD_LAT + 2);

  ppu_state_e        state, state_nxt;
  logic [DCNT_W-1:0] drain_cnt;
  logic              layers_ready;
  logic              issue;
  logic              start_mix;
  logic              advance;
  logic [RD_LAT-1:0] dl_vld;
  logic [ADDR_W-1:0] dl_addr [RD_LAT];
  logic [PIX_W-1:0]  resolved;

  assign layers_ready = &(layer_done | ~layer_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Any prep restarts the row from WAIT, even when the engines are already ready.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_mix = 1'b0;
    advance   = 1'b0;
    mix_done  = 1'b0;
    unique case (state)
      IDLE:  if (prep) state_nxt = WAIT;
      WAIT: begin
        if (prep) begin
          state_nxt = WAIT;
        end else if (layers_ready) begin
          state_nxt = MIX;
          start_mix = 1'b1;
        end
      end
      MIX: begin
        issue = 1'b1;
        if (prep)                           state_nxt = WAIT;
        else if (pixel_addr == LAST_ADDR)   state_nxt = DRAIN;
        else                                advance   = 1'b1;
      end
      DRAIN: begin
        if (prep)                                  state_nxt = WAIT;
        else if (drain_cnt == DCNT_W'(RD_LAT))     state_nxt = DONE;
      end
      DONE: begin
        mix_done = 1'b1;
        if (prep) state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      drain_cnt  <= '0;
    end else begin
      if (start_mix)    pixel_addr <= '0;
      else if (advance) pixel_addr <= pixel_addr + ADDR_W'(1);
      if (state == DRAIN) drain_cnt <= drain_cnt + DCNT_W'(1);
      else                drain_cnt <= '0;
    end
  end

  // Write address travels with the read so it lines up with the returning buffer data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dl_addr[i] <= '0;
    end else begin
      dl_vld[0]  <= issue & ~prep;
      dl_addr[0] <= pixel_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1] & ~prep;
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

  layer_prio_resolve #(
    .NUM_LAYERS (NUM_LAYERS),
    .PAL_W      (PAL_W),
    .COL_W      (COL_W),
    .PRIO_W     (PRIO_W),
    .PIX_W      (PIX_W)
  ) u_resolve (
    .layer_en    (layer_en),
    .layer_pixel (layer_pixel),
    .layer_prio  (layer_prio),
    .win_pixel   (resolved)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowram_wren   <= 1'b0;
      rowram_wraddr <= '0;
      rowram_wrdata <= '0;
    end else begin
      rowram_wren <= dl_vld[RD_LAT-1] & ~prep;
      if (dl_vld[RD_LAT-1] && !prep) begin
        rowram_wraddr <= dl_addr[RD_LAT-1];
        rowram_wrdata <= resolved;
      end
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// tb/tb_layer_mixer.sv - self-checking bench for layer_mixer at read latencies 1 and 3.
module tb_layer_mixer;

  localparam int NL = 3, RW = 320, PAL_W = 5, COL_W = 4, PRIO_W = 2, AW = 9, PW = 9;
  localparam int LOGSZ = 16384;

  typedef struct packed {
    logic [2:0]  en;
    logic [2:0]  done;
    logic [26:0] pix;
    logic [5:0]  prio;
    logic [8:0]  exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, prep = 1'b0;
  logic [NL-1:0] layer_en = '0, layer_done = '0;
  logic [AW-1:0] pa [2];
  logic [NL*PW-1:0] lp [2];
  logic [NL*PRIO_W-1:0] lpr [2];
  logic [PW-1:0] wd [2];
  logic [AW-1:0] wa [2];
  logic we [2], md [2];
  int rdl [2] = '{1, 3};

  always #5 clk = ~clk;

  layer_mixer #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .prep(prep), .layer_en(layer_en), .layer_done(layer_done),
    .pixel_addr(pa[0]), .layer_pixel(lp[0]), .layer_prio(lpr[0]),
    .rowram_wrdata(wd[0]), .rowram_wraddr(wa[0]), .rowram_wren(we[0]), .mix_done(md[0]));

  layer_mixer #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .prep(prep), .layer_en(layer_en), .layer_done(layer_done),
    .pixel_addr(pa[1]), .layer_pixel(lp[1]), .layer_prio(lpr[1]),
    .rowram_wrdata(wd[1]), .rowram_wraddr(wa[1]), .rowram_wren(we[1]), .mix_done(md[1]));

  // Engine line buffers: row content tables read through a latency-matched address pipe.
  logic [PW-1:0]     pix_tab  [NL][RW];
  logic [PRIO_W-1:0] prio_tab [NL][RW];
  logic [AW-1:0]     rd1_a;
  logic [AW-1:0]     rd3_a [3];

  always_ff @(posedge clk) begin
    rd1_a    <= pa[0];
    rd3_a[0] <= pa[1];
    rd3_a[1] <= rd3_a[0];
    rd3_a[2] <= rd3_a[1];
  end

  always_comb begin
    lp[0] = '0; lp[1] = '0; lpr[0] = '0; lpr[1] = '0;
    for (int i = 0; i < NL; i++) begin
      if (rd1_a < AW'(RW)) begin
        lp[0][i*PW +: PW]          = pix_tab[i][rd1_a];
        lpr[0][i*PRIO_W +: PRIO_W] = prio_tab[i][rd1_a];
      end
      if (rd3_a[2] < AW'(RW)) begin
        lp[1][i*PW +: PW]          = pix_tab[i][rd3_a[2]];
        lpr[1][i*PRIO_W +: PRIO_W] = prio_tab[i][rd3_a[2]];
      end
    end
  end

  // Write log per DUT, only ever appended by this monitor.
  int cyc = 0;
  int wr_total [2] = '{0, 0};
  logic [AW-1:0] wr_addr [2][LOGSZ];
  logic [PW-1:0] wr_data [2][LOGSZ];
  int wr_cyc [2][LOGSZ];
  int md_rise [2] = '{0, 0};
  logic md_q [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d] === 1'b1) begin
        if (wr_total[d] < LOGSZ) begin
          wr_addr[d][wr_total[d]] = wa[d];
          wr_data[d][wr_total[d]] = wd[d];
          wr_cyc[d][wr_total[d]]  = cyc;
        end
        wr_total[d] = wr_total[d] + 1;
      end
      if (md[d] === 1'b1 && md_q[d] !== 1'b1) md_rise[d] = cyc;
      md_q[d] = md[d];
    end
  end

  int n_cmp = 0, n_bad = 0;
  int base [2];
  int prep_cyc, d_eff;
  logic [PW-1:0] exp_row [RW];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: rank each opaque enabled layer by (prio, then lower index) as one score.
  function automatic logic [PW-1:0] ref_pixel(input logic [NL-1:0] en, input int a);
    int best = -1;
    logic [PW-1:0] r = '0;
    for (int i = 0; i < NL; i++) begin
      if (en[i] && pix_tab[i][a][COL_W-1:0] != '0) begin
        int s = int'(prio_tab[i][a]) * NL + (NL - 1 - i);
        if (s > best) begin best = s; r = pix_tab[i][a]; end
      end
    end
    return r;
  endfunction

  task automatic fill_expected(input logic [NL-1:0] en);
    for (int a = 0; a < RW; a++) exp_row[a] = ref_pixel(en, a);
  endtask

  task automatic start_row(input logic [NL-1:0] en, input logic [NL-1:0] done_v,
                           input int dly, input bit dbl);
    @(posedge clk); #2;
    for (int d = 0; d < 2; d++) base[d] = wr_total[d];
    layer_en   = en;
    layer_done = done_v & ~en;
    prep       = 1'b1;
    prep_cyc   = cyc;
    d_eff      = (en == '0) ? 1 : dly;
    if (dbl) begin
      @(posedge clk); #2;
      prep_cyc   = cyc;
      layer_done = done_v;
      d_eff      = 1;
    end
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #2;
      prep = 1'b0;
    end
    layer_done = done_v;
  endtask

  task automatic check_row(input int d);
    int n = wr_total[d] - base[d];
    int bad_a = 0, bad_c = 0, bad_d = 0, first_bad = -1;
    check($sformatf("d%0d_write_count", d), n, RW);
    if (n > 0 && base[d] + n <= LOGSZ) begin
      for (int k = 0; k < n && k < RW; k++) begin
        if (int'(wr_addr[d][base[d]+k]) != k) bad_a++;
        if (wr_cyc[d][base[d]+k] != wr_cyc[d][base[d]] + k) bad_c++;
        if (wr_data[d][base[d]+k] !== exp_row[k]) begin
          bad_d++;
          if (first_bad < 0) first_bad = k;
        end
      end
      check($sformatf("d%0d_addr_sequence", d), bad_a, 0);
      check($sformatf("d%0d_contiguous", d), bad_c, 0);
      check($sformatf("d%0d_data(first_bad_addr=%0d)", d, first_bad), bad_d, 0);
      check($sformatf("d%0d_first_write_cycle", d), wr_cyc[d][base[d]],
            prep_cyc + d_eff + rdl[d] + 2);
      check($sformatf("d%0d_mix_done_cycle", d), md_rise[d], wr_cyc[d][base[d]+n-1] + 1);
    end
  endtask

  task automatic finish_row(input bit drop);
    int t = 0;
    while (!(md[0] === 1'b1 && md[1] === 1'b1) && t < 2000) begin
      @(posedge clk); #2;
      t++;
      if (drop && (wr_total[0] - base[0]) >= 10) layer_done = '0;
    end
    check("row_completes_in_budget", int'(t < 2000), 1);
    repeat (3) @(posedge clk);
    #2;
    check_row(0);
    check_row(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_pixel_addr", tag, d), int'(pa[d]), 0);
      check($sformatf("%s_d%0d_wren", tag, d), int'(we[d]), 0);
      check($sformatf("%s_d%0d_wraddr", tag, d), int'(wa[d]), 0);
      check($sformatf("%s_d%0d_wrdata", tag, d), int'(wd[d]), 0);
      check($sformatf("%s_d%0d_mix_done", tag, d), int'(md[d]), 0);
    end
  endtask

  task automatic random_tables();
    for (int a = 0; a < RW; a++)
      for (int i = 0; i < NL; i++) begin
        logic [COL_W-1:0] c = ($urandom_range(0, 2) == 0) ? '0 : COL_W'($urandom_range(1, 15));
        pix_tab[i][a]  = {PAL_W'($urandom_range(0, 31)), c};
        prio_tab[i][a] = PRIO_W'($urandom_range(0, 3));
      end
  endtask

  initial begin
    vec_t vecs [10];
    int snap [2];
    int t;
    vecs[0] = '{3'b111, 3'b111, {9'h080, 9'h120, 9'h010}, {2'd3, 2'd2, 2'd1}, 9'h000};
    vecs[1] = '{3'b111, 3'b111, {{5'd7, 4'd2}, 9'h000, {5'd3, 4'd5}}, {2'd2, 2'd0, 2'd1}, {5'd7, 4'd2}};
    vecs[2] = '{3'b111, 3'b111, {{5'd7, 4'd2}, 9'h000, {5'd3, 4'd5}}, {2'd1, 2'd0, 2'd1}, {5'd3, 4'd5}};
    vecs[3] = '{3'b011, 3'b011, {{5'd7, 4'd2}, {5'd4, 4'd1}, {5'd3, 4'd5}}, {2'd3, 2'd2, 2'd1}, {5'd4, 4'd1}};
    vecs[4] = '{3'b000, 3'b000, {{5'd3, 4'd3}, {5'd2, 4'd2}, {5'd1, 4'd1}}, {2'd3, 2'd3, 2'd3}, 9'h000};
    vecs[5] = '{3'b111, 3'b111, {{5'd3, 4'd3}, {5'd2, 4'd2}, {5'd1, 4'd1}}, {2'd3, 2'd3, 2'd3}, {5'd1, 4'd1}};
    vecs[6] = '{3'b111, 3'b111, {{5'd3, 4'd3}, {5'd2, 4'd2}, {5'd1, 4'd1}}, {2'd3, 2'd3, 2'd0}, {5'd2, 4'd2}};
    vecs[7] = '{3'b111, 3'b111, {{5'd3, 4'd0}, {5'd2, 4'd2}, {5'd9, 4'd0}}, {2'd3, 2'd0, 2'd3}, {5'd2, 4'd2}};
    vecs[8] = '{3'b101, 3'b101, {{5'd3, 4'd3}, {5'd2, 4'd2}, {5'd1, 4'd1}}, {2'd1, 2'd3, 2'd0}, {5'd3, 4'd3}};
    vecs[9] = '{3'b111, 3'b111, {{5'd31, 4'd15}, {5'd2, 4'd2}, {5'd1, 4'd1}}, {2'd3, 2'd2, 2'd2}, {5'd31, 4'd15}};

    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("idle_no_writes", wr_total[0] + wr_total[1], 0);

    for (int v = 0; v < 10; v++) begin
      for (int a = 0; a < RW; a++) begin
        for (int i = 0; i < NL; i++) begin
          pix_tab[i][a]  = vecs[v].pix[i*PW +: PW];
          prio_tab[i][a] = vecs[v].prio[i*PRIO_W +: PRIO_W];
        end
        exp_row[a] = vecs[v].exp;
      end
      start_row(vecs[v].en, vecs[v].done, 1, 1'b0);
      finish_row(1'b0);
    end

    // Address-encoded content: a misaligned read pipe shows up as wrong data per address.
    for (int a = 0; a < RW; a++) begin
      logic [AW-1:0] av = AW'(a);
      pix_tab[0][a]  = {av[8:4], av[3:0] | 4'd1};
      prio_tab[0][a] = 2'd1;
      pix_tab[1][a]  = '0; prio_tab[1][a] = 2'd3;
      pix_tab[2][a]  = '0; prio_tab[2][a] = 2'd0;
    end
    fill_expected(3'b111);
    start_row(3'b111, 3'b111, 1, 1'b0);
    finish_row(1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [NL-1:0] en = NL'($urandom_range(0, 7));
      random_tables();
      fill_expected(en);
      start_row(en, 3'b111, (r == 3) ? 1 : $urandom_range(1, 4), r == 3);
      finish_row(r == 2);
    end

    // Abort by prep during the 100th write of a row.
    random_tables();
    fill_expected(3'b111);
    start_row(3'b111, 3'b111, 1, 1'b0);
    t = 0;
    while (!((wr_total[0] - base[0]) == 99 && we[0] === 1'b1) && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    check("abort_reached_write_100", int'(t < 1000), 1);
    prep     = 1'b1;
    prep_cyc = cyc;
    snap[0]  = base[0] + 100;
    snap[1]  = wr_total[1] + ((we[1] === 1'b1) ? 1 : 0);
    @(posedge clk); #2;
    prep       = 1'b0;
    layer_done = '0;
    repeat (10) @(posedge clk);
    #2;
    check("abort_d0_no_further_writes", wr_total[0], snap[0]);
    check("abort_d1_no_further_writes", wr_total[1], snap[1]);
    check("abort_wren_low", int'(we[0]) + int'(we[1]), 0);
    for (int d = 0; d < 2; d++) base[d] = wr_total[d];
    layer_done = 3'b111;
    d_eff      = cyc - prep_cyc;
    finish_row(1'b0);

    // Asynchronous reset in the middle of a sweep.
    random_tables();
    fill_expected(3'b011);
    start_row(3'b011, 3'b111, 2, 1'b0);
    t = 0;
    while ((wr_total[0] - base[0]) < 50 && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    check("reset_reached_write_50", int'(t < 1000), 1);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    snap[0] = wr_total[0];
    snap[1] = wr_total[1];
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("post_reset_d0_no_writes", wr_total[0], snap[0]);
    check("post_reset_d1_no_writes", wr_total[1], snap[1]);
    check("post_reset_mix_done_low", int'(md[0]) + int'(md[1]), 0);
    start_row(3'b011, 3'b111, 1, 1'b0);
    finish_row(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
